// File: rtl/gh18b20_sched_if.sv
// -----------------------------------------------------------------------------
// gh18b20_sched_if
// Handshake bundle between the measurement scheduler and the sensor
// controller that performs one conversion/read per request.
//   conv_start : scheduler -> controller, one-cycle pulse, start a conversion
//   conv_done  : controller -> scheduler, one-cycle pulse, raw_* valid
//   conv_err   : controller -> scheduler, one-cycle pulse, conversion failed
//   raw_data   : controller -> scheduler, 20-bit temperature magnitude
//   raw_sign   : controller -> scheduler, 1 = negative temperature
// master = scheduler side, slave = sensor controller side.
// -----------------------------------------------------------------------------
interface gh18b20_sched_if;
  logic        conv_start;
  logic        conv_done;
  logic        conv_err;
  logic [19:0] raw_data;
  logic        raw_sign;

  modport master (
    output conv_start,
    input  conv_done,
    input  conv_err,
    input  raw_data,
    input  raw_sign
  );

  modport slave (
    input  conv_start,
    output conv_done,
    output conv_err,
    output raw_data,
    output raw_sign
  );
endinterface

// File: rtl/gh18b20_sched.sv
// -----------------------------------------------------------------------------
// gh18b20_sched
// Periodic / on-demand temperature measurement scheduler. Issues one
// conversion request, waits (with timeout) for the result, keeps the last good
// reading, tracks an over-temperature alarm with hysteresis and counts failed
// conversions. Between conversions a programmable idle gap is inserted.
//
// Ports:
//   sys_clk     in   system clock (sole clock)
//   sys_rst_n   in   synchronous active-low reset
//   enable      in   level, 1 = periodic measurement running
//   trig        in   one-cycle pulse, request an immediate measurement
//   sensor      if   master side of gh18b20_sched_if (conv_start/done/err/raw)
//   temp_data   out  last good temperature magnitude
//   temp_sign   out  last good temperature sign (1 = negative)
//   temp_valid  out  one-cycle pulse, temp_data/temp_sign were updated
//   busy        out  high while a conversion is being issued or awaited
//   alarm       out  over-temperature flag with hysteresis
//   err_cnt     out  failed-conversion count, saturating at 255
// -----------------------------------------------------------------------------
module gh18b20_sched #(
  parameter int          PERIOD_CYC  = 50_000_000,
  parameter int          TIMEOUT_CYC = 45_000_000,
  parameter logic [19:0] HI_TH       = 20'd300000,
  parameter logic [19:0] HYST        = 20'd10000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic               trig,
  gh18b20_sched_if.master    sensor,
  output logic [19:0]        temp_data,
  output logic               temp_sign,
  output logic               temp_valid,
  output logic               busy,
  output logic               alarm,
  output logic [7:0]         err_cnt
);

  // Counters are sized to hold their parameter value so they never wrap.
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(PERIOD_CYC + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  // Alarm release level; constant, cannot underflow while HYST <= HI_TH.
  localparam logic [19:0] LO_TH = HI_TH - HYST;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          enable_d_reg;
  logic          conv_start_reg;
  logic [19:0]   temp_data_reg;
  logic          temp_sign_reg;
  logic          temp_valid_reg;
  logic          busy_reg;
  logic          alarm_reg;
  logic [7:0]    err_cnt_reg;

  // A conversion fails on an explicit error (which wins over a simultaneous
  // done) or when the last allowed wait cycle passes without a done.
  logic conv_fail;
  assign conv_fail = sensor.conv_err
                     || (!sensor.conv_done && (tmo_cnt_reg == TMO_LAST));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg      <= IDLE;
      tmo_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      enable_d_reg   <= 1'b0;
      conv_start_reg <= 1'b0;
      temp_data_reg  <= '0;
      temp_sign_reg  <= 1'b0;
      temp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      alarm_reg      <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      enable_d_reg   <= enable;
      conv_start_reg <= 1'b0;
      temp_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (enable || trig) begin
            state_reg      <= ISSUE;
            conv_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
          end
        end

        ISSUE: begin
          // done/err seen during the request cycle are stale and ignored.
          state_reg   <= WAIT;
          tmo_cnt_reg <= '0;
        end

        WAIT: begin
          if (conv_fail) begin
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
            state_reg   <= GAP;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
          end else if (sensor.conv_done) begin
            temp_data_reg  <= sensor.raw_data;
            temp_sign_reg  <= sensor.raw_sign;
            temp_valid_reg <= 1'b1;
            if (!sensor.raw_sign && (sensor.raw_data >= HI_TH)) begin
              alarm_reg <= 1'b1;
            end else if (sensor.raw_sign || (sensor.raw_data < LO_TH)) begin
              alarm_reg <= 1'b0;
            end
            state_reg   <= GAP;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
          end
        end

        GAP: begin
          if (trig) begin
            // An explicit request cuts the gap short.
            state_reg      <= ISSUE;
            conv_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
            gap_cnt_reg    <= '0;
          end else if (enable_d_reg && !enable) begin
            // Periodic mode switched off while idling: stop right away.
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
          end else if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            if (enable) begin
              state_reg      <= ISSUE;
              conv_start_reg <= 1'b1;
              busy_reg       <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sensor.conv_start = conv_start_reg;
  assign temp_data         = temp_data_reg;
  assign temp_sign         = temp_sign_reg;
  assign temp_valid        = temp_valid_reg;
  assign busy              = busy_reg;
  assign alarm             = alarm_reg;
  assign err_cnt           = err_cnt_reg;

endmodule

// File: tb/tb_gh18b20_sched.sv
// -----------------------------------------------------------------------------
// tb_gh18b20_sched
// Directed plus randomized bench for gh18b20_sched with a short gap/timeout.
// The bench plays the sensor controller, and a transaction-level model holds
// the expected last reading, alarm level and error count.
// -----------------------------------------------------------------------------
module tb_gh18b20_sched;
  localparam int          PERIOD = 10;
  localparam int          TMO    = 20;
  localparam logic [19:0] HI_TH  = 20'd300000;
  localparam logic [19:0] HYST   = 20'd10000;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        enable  = 1'b0;
  logic        trig    = 1'b0;
  logic [19:0] temp_data;
  logic        temp_sign;
  logic        temp_valid;
  logic        busy;
  logic        alarm;
  logic [7:0]  err_cnt;

  gh18b20_sched_if sif ();

  gh18b20_sched #(
    .PERIOD_CYC  (PERIOD),
    .TIMEOUT_CYC (TMO),
    .HI_TH       (HI_TH),
    .HYST        (HYST)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .enable     (enable),
    .trig       (trig),
    .sensor     (sif),
    .temp_data  (temp_data),
    .temp_sign  (temp_sign),
    .temp_valid (temp_valid),
    .busy       (busy),
    .alarm      (alarm),
    .err_cnt    (err_cnt)
  );

  always #10 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int n_start = 0;
  int n_valid = 0;

  // Reference model state: last good reading, alarm level, error count.
  logic [19:0] m_data  = '0;
  logic        m_sign  = 1'b0;
  logic        m_alarm = 1'b0;
  int          m_err   = 0;

  logic [19:0] hv [5] = '{20'd300000, 20'd295000, 20'd289999, 20'd300000, 20'd300000};
  logic        hs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        ha [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    sif.conv_done = 1'b0;
    sif.conv_err  = 1'b0;
    sif.raw_data  = '0;
    sif.raw_sign  = 1'b0;
  end

  always @(negedge clk) begin
    if (sif.conv_start === 1'b1) n_start <= n_start + 1;
    if (temp_valid === 1'b1) n_valid <= n_valid + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until conv_start is seen; k = number of clock edges waited.
  task automatic wait_start(output int k);
    k = 0;
    while (sif.conv_start !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
  endtask

  // Called at the sample point of the request cycle. Responds in wait cycle d
  // (d = TMO with K_NONE lets the timeout fire), optionally injects a stale
  // done in the request cycle (stray_at = 0) or a trig during the wait.
  task automatic conv(input int kind, input int d, input logic [19:0] data,
                      input logic sign, input int stray_at, input int trig_at);
    for (int i = 0; i < d; i++) begin
      sif.conv_done = (i == stray_at);
      sif.raw_data  = data ^ 20'h5A5A5;
      sif.raw_sign  = ~sign;
      trig          = (i == trig_at);
      tick();
    end
    sif.conv_done = 1'b0;
    trig          = 1'b0;
    if (kind != K_NONE) begin
      sif.conv_done = (kind == K_DONE) || (kind == K_BOTH);
      sif.conv_err  = (kind == K_ERR) || (kind == K_BOTH);
      sif.raw_data  = data;
      sif.raw_sign  = sign;
    end
    tick();
    sif.conv_done = 1'b0;
    sif.conv_err  = 1'b0;

    if (kind == K_DONE) begin
      m_data = data;
      m_sign = sign;
      if (!sign && data >= HI_TH) m_alarm = 1'b1;
      else if (sign || data < HI_TH - HYST) m_alarm = 1'b0;
    end else begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end

    chk("temp_valid", 32'(temp_valid), 32'(kind == K_DONE));
    chk("temp_data", 32'(temp_data), 32'(m_data));
    chk("temp_sign", 32'(temp_sign), 32'(m_sign));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("busy_gap", 32'(busy), 32'd0);
    tick();
    chk("valid_one_cycle", 32'(temp_valid), 32'd0);
  endtask

  initial begin
    int k;
    int ns;
    int nv;
    int kind;
    int d;
    logic [19:0] rd;
    logic rs;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_conv_start", 32'(sif.conv_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_temp_data", 32'(temp_data), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_temp_valid", 32'(temp_valid), 32'd0);

    // Periodic mode from reset: first request one edge after release
    enable = 1'b1;
    rst_n  = 1'b1;
    wait_start(k);
    chk("first_start_lat", 32'(k), 32'd1);
    chk("busy_issue", 32'(busy), 32'd1);
    conv(K_DONE, 5, 20'd250000, 1'b0, -1, -1);
    chk("basic_data", 32'(temp_data), 32'd250000);
    wait_start(k);
    chk("start_spacing", 32'(5 + 2 + k), 32'd16);

    // Hysteresis sequence
    for (int i = 0; i < 5; i++) begin
      conv(K_DONE, 3, hv[i], hs[i], -1, -1);
      chk("hyst_alarm", 32'(alarm), 32'(ha[i]));
      wait_start(k);
      chk("gap_len", 32'(k), 32'(PERIOD - 1));
    end

    // Timeout, then error racing a done, then a stale done in the request cycle
    conv(K_NONE, TMO, 20'd0, 1'b0, -1, -1);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
    chk("tmo_data_kept", 32'(temp_data), 32'd300000);
    wait_start(k);
    chk("tmo_gap", 32'(k), 32'(PERIOD - 1));
    conv(K_BOTH, 4, 20'd111111, 1'b0, -1, -1);
    chk("both_err_cnt", 32'(err_cnt), 32'd2);
    wait_start(k);
    conv(K_DONE, 3, 20'd123456, 1'b0, 0, -1);
    chk("stray_ignored", 32'(temp_data), 32'd123456);
    wait_start(k);

    // Randomized conversions against the model
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      d    = (kind == K_NONE) ? TMO : int'($urandom_range(1, TMO));
      rd   = ($urandom_range(0, 3) != 0) ? 20'($urandom_range(280000, 310000))
                                         : 20'($urandom);
      rs   = ($urandom_range(0, 3) == 0);
      conv(kind, d, rd, rs, -1, -1);
      wait_start(k);
      chk("rand_gap", 32'(k), 32'(PERIOD - 1));
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      conv(K_ERR, 1, 20'd0, 1'b0, -1, -1);
      wait_start(k);
    end
    chk("err_saturated", 32'(err_cnt), 32'd255);

    // enable falling in the gap returns to IDLE at once, so re-raising it
    // starts a new request without waiting for the gap to expire
    conv(K_DONE, 2, 20'd200000, 1'b0, -1, -1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("en_fall_gap_idle", 32'(sif.conv_start), 32'd1);

    // enable dropped in the request cycle: conversion still completes
    enable = 1'b0;
    conv(K_DONE, 4, 20'd210000, 1'b0, -1, -1);
    ns = n_start;
    repeat (PERIOD + 5) tick();
    chk("en_low_no_restart", 32'(n_start), 32'(ns));
    chk("en_low_busy", 32'(busy), 32'd0);

    // trig in IDLE: one request, trig during WAIT not queued
    ns = n_start;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("trig_latency", 32'(sif.conv_start), 32'd1);
    conv(K_DONE, 6, 20'd220000, 1'b0, -1, 3);
    repeat (PERIOD + 5) tick();
    chk("trig_one_start", 32'(n_start), 32'(ns + 1));

    // trig inside the gap starts the next request immediately
    trig = 1'b1;
    tick();
    trig = 1'b0;
    conv(K_DONE, 2, 20'd230000, 1'b0, -1, -1);
    repeat (3) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("trig_gap_start", 32'(sif.conv_start), 32'd1);
    conv(K_DONE, 3, 20'd240000, 1'b1, -1, -1);
    repeat (PERIOD + 5) tick();

    // Reset three cycles into WAIT, then a late done arriving in IDLE
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nv = n_valid;
    tick();
    sif.conv_done = 1'b1;
    sif.raw_data  = 20'd305000;
    sif.raw_sign  = 1'b0;
    tick();
    sif.conv_done = 1'b0;
    tick();
    chk("rstw_temp_data", 32'(temp_data), 32'd0);
    chk("rstw_temp_sign", 32'(temp_sign), 32'd0);
    chk("rstw_alarm", 32'(alarm), 32'd0);
    chk("rstw_err_cnt", 32'(err_cnt), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_conv_start", 32'(sif.conv_start), 32'd0);
    chk("rstw_no_valid", 32'(n_valid), 32'(nv));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
